// File: rtl/hamming23_syndrome_pipe_if.sv
// Handshake and data bundle for the Hamming(23,18) syndrome/error-locator stage.
// The slave view belongs to the pipeline; the master view belongs to whatever feeds and drains it.
interface hamming23_syndrome_pipe_if #(
  parameter int CNT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [22:0]       in_word;
  logic              out_valid;
  logic              out_ready;
  logic [22:0]       out_word;
  logic [22:0]       out_mask;
  logic [4:0]        out_syn;
  logic              out_corr;
  logic              out_uncorr;
  logic [CNT_W-1:0]  corr_cnt;
  logic [CNT_W-1:0]  uncorr_cnt;

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_word, out_mask, out_syn,
           out_corr, out_uncorr, corr_cnt, uncorr_cnt
  );

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_word, out_mask, out_syn,
           out_corr, out_uncorr, corr_cnt, uncorr_cnt
  );
endinterface

// File: rtl/hamming23_syndrome_pipe.sv
// Two-stage Hamming(23,18) error locator: S1 computes the syndrome, S2 decodes it into a
// one-hot correction mask aligned with the received word, with saturating statistics.
module hamming23_syndrome_pipe #(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hamming23_syndrome_pipe_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Syndrome is the XOR of the 1-based positions of every set bit.
  function automatic logic [4:0] calc_syn(input logic [22:0] w);
    logic [4:0] s;
    s = 5'd0;
    for (int i = 0; i < 23; i++) begin
      s = s ^ (w[i] ? 5'(i + 1) : 5'd0);
    end
    return s;
  endfunction

  // Returns {corr, uncorr, mask}.
  function automatic logic [24:0] decode_mask(input logic [4:0] syn);
    logic [24:0] r;
    if (syn == 5'd0) begin
      r = 25'd0;
    end else if (syn <= 5'd23) begin
      r = {1'b1, 1'b0, (23'd1 << (syn - 5'd1))};
    end else begin
      r = {1'b0, 1'b1, 23'd0};
    end
    return r;
  endfunction

  logic              alive_q, alive_d;
  logic              s1_valid_q, s1_valid_d;
  logic [22:0]       s1_word_q, s1_word_d;
  logic [4:0]        s1_syn_q, s1_syn_d;
  logic              s2_valid_q, s2_valid_d;
  logic [22:0]       s2_word_q, s2_word_d;
  logic [4:0]        s2_syn_q, s2_syn_d;
  logic [22:0]       s2_mask_q, s2_mask_d;
  logic              s2_corr_q, s2_corr_d;
  logic              s2_uncorr_q, s2_uncorr_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;
  logic              s2_adv_s, s1_adv_s, in_ready_s, out_xfer_s;
  logic [24:0]       dec_s;

  // Handshake, next-state of both stages and the saturating counters.
  always_comb begin
    out_xfer_s = s2_valid_q && bus.out_ready;
    s2_adv_s   = !s2_valid_q || out_xfer_s;
    s1_adv_s   = !s1_valid_q || s2_adv_s;
    // alive_q keeps in_ready low until the first edge after reset release.
    in_ready_s = alive_q && s1_adv_s;
    alive_d    = 1'b1;
    dec_s      = decode_mask(s1_syn_q);

    if (s1_adv_s) begin
      s1_valid_d = bus.in_valid && in_ready_s;
      s1_word_d  = bus.in_word;
      s1_syn_d   = calc_syn(bus.in_word);
    end else begin
      s1_valid_d = s1_valid_q;
      s1_word_d  = s1_word_q;
      s1_syn_d   = s1_syn_q;
    end

    if (s2_adv_s) begin
      s2_valid_d  = s1_valid_q;
      s2_word_d   = s1_word_q;
      s2_syn_d    = s1_syn_q;
      s2_corr_d   = dec_s[24];
      s2_uncorr_d = dec_s[23];
      s2_mask_d   = dec_s[22:0];
    end else begin
      s2_valid_d  = s2_valid_q;
      s2_word_d   = s2_word_q;
      s2_syn_d    = s2_syn_q;
      s2_corr_d   = s2_corr_q;
      s2_uncorr_d = s2_uncorr_q;
      s2_mask_d   = s2_mask_q;
    end

    if (out_xfer_s && s2_corr_q && (corr_cnt_q != CNT_MAX)) begin
      corr_cnt_d = corr_cnt_q + CNT_ONE;
    end else begin
      corr_cnt_d = corr_cnt_q;
    end

    if (out_xfer_s && s2_uncorr_q && (uncorr_cnt_q != CNT_MAX)) begin
      uncorr_cnt_d = uncorr_cnt_q + CNT_ONE;
    end else begin
      uncorr_cnt_d = uncorr_cnt_q;
    end
  end

  // Pipeline and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q      <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_word_q    <= 23'd0;
      s1_syn_q     <= 5'd0;
      s2_valid_q   <= 1'b0;
      s2_word_q    <= 23'd0;
      s2_syn_q     <= 5'd0;
      s2_mask_q    <= 23'd0;
      s2_corr_q    <= 1'b0;
      s2_uncorr_q  <= 1'b0;
      corr_cnt_q   <= {CNT_W{1'b0}};
      uncorr_cnt_q <= {CNT_W{1'b0}};
    end else begin
      alive_q      <= alive_d;
      s1_valid_q   <= s1_valid_d;
      s1_word_q    <= s1_word_d;
      s1_syn_q     <= s1_syn_d;
      s2_valid_q   <= s2_valid_d;
      s2_word_q    <= s2_word_d;
      s2_syn_q     <= s2_syn_d;
      s2_mask_q    <= s2_mask_d;
      s2_corr_q    <= s2_corr_d;
      s2_uncorr_q  <= s2_uncorr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_word   = s2_word_q;
  assign bus.out_mask   = s2_mask_q;
  assign bus.out_syn    = s2_syn_q;
  assign bus.out_corr   = s2_corr_q;
  assign bus.out_uncorr = s2_uncorr_q;
  assign bus.corr_cnt   = corr_cnt_q;
  assign bus.uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming23_syndrome_pipe.sv
// Scoreboard bench: the driver queues hand-computed responses on each accepted word and a
// negedge monitor checks every delivered word, the counters and stall stability.
module tb_hamming23_syndrome_pipe;

  localparam int CNT_W = 4;

  typedef struct {
    logic [22:0] w;
    logic [22:0] m;
    logic [4:0]  s;
    logic        c;
    logic        u;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  vec_t exp_q[$];
  int   mdl_corr;
  int   mdl_uncorr;
  logic        stall_prev;
  logic [22:0] snap_word;
  logic [22:0] snap_mask;
  logic [4:0]  snap_syn;

  hamming23_syndrome_pipe_if #(.CNT_W(CNT_W)) bus ();

  hamming23_syndrome_pipe #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [22:0] w, input logic [22:0] m, input logic [4:0] s,
                      input logic c, input logic u);
    vec_t v;
    int   budget;
    budget = 0;
    v.w = w; v.m = m; v.s = s; v.c = c; v.u = u;
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    @(negedge clk);
    while (!bus.in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(v);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: counters every cycle, scoreboard on each transfer, stability while stalled.
  initial begin
    vec_t e;
    mdl_corr = 0;
    mdl_uncorr = 0;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        mdl_corr = 0;
        mdl_uncorr = 0;
        stall_prev = 1'b0;
      end else begin
        check("corr_cnt", 32'(bus.corr_cnt), 32'(mdl_corr));
        check("uncorr_cnt", 32'(bus.uncorr_cnt), 32'(mdl_uncorr));
        if (stall_prev && bus.out_valid) begin
          check("stall_word", 32'(bus.out_word), 32'(snap_word));
          check("stall_mask", 32'(bus.out_mask), 32'(snap_mask));
          check("stall_syn", 32'(bus.out_syn), 32'(snap_syn));
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        snap_word  = bus.out_word;
        snap_mask  = bus.out_mask;
        snap_syn   = bus.out_syn;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(bus.out_word), 32'h0BAD0BAD);
          end else begin
            e = exp_q.pop_front();
            check("out_word", 32'(bus.out_word), 32'(e.w));
            check("out_mask", 32'(bus.out_mask), 32'(e.m));
            check("out_syn", 32'(bus.out_syn), 32'(e.s));
            check("out_corr", 32'(bus.out_corr), 32'(e.c));
            check("out_uncorr", 32'(bus.out_uncorr), 32'(e.u));
            check("corrected", 32'(bus.out_word ^ bus.out_mask), 32'(e.w ^ e.m));
            if (e.c && mdl_corr < 15) mdl_corr++;
            if (e.u && mdl_uncorr < 15) mdl_uncorr++;
          end
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_word   = 23'd0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_word", 32'(bus.out_word), 32'd0);
    check("rst_out_mask", 32'(bus.out_mask), 32'd0);
    check("rst_out_syn", 32'(bus.out_syn), 32'd0);
    check("rst_flags", 32'({bus.out_corr, bus.out_uncorr}), 32'd0);
    check("rst_cnts", 32'({bus.corr_cnt, bus.uncorr_cnt}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(bus.in_ready), 32'd1);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // Latency: accepted at edge n, visible after edge n+1.
    bus.out_ready = 1'b1;
    send(23'h000000, 23'h000000, 5'd0, 1'b0, 1'b0);
    check("lat_not_yet", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_valid", 32'(bus.out_valid), 32'd1);
    wait_drain();

    send(23'h000010, 23'h000010, 5'd5,  1'b1, 1'b0);
    send(23'h008080, 23'h000000, 5'd24, 1'b0, 1'b1);
    send(23'h000001, 23'h000001, 5'd1,  1'b1, 1'b0);
    send(23'h400000, 23'h400000, 5'd23, 1'b1, 1'b0);
    send(23'h000003, 23'h000004, 5'd3,  1'b1, 1'b0);
    send(23'h7FFFFF, 23'h000000, 5'd0,  1'b0, 1'b0);
    send(23'h440000, 23'h000008, 5'd4,  1'b1, 1'b0);
    send(23'h600000, 23'h000001, 5'd1,  1'b1, 1'b0);
    send(23'h00C000, 23'h000000, 5'd31, 1'b0, 1'b1);
    send(23'h0C0000, 23'h000040, 5'd7,  1'b1, 1'b0);
    send(23'h000007, 23'h000000, 5'd0,  1'b0, 1'b0);
    wait_drain();

    // Backpressure: stall the output for four cycles while four words stream in.
    fork
      begin
        send(23'h000002, 23'h000002, 5'd2,  1'b1, 1'b0);
        send(23'h000800, 23'h000800, 5'd12, 1'b1, 1'b0);
        send(23'h008080, 23'h000000, 5'd24, 1'b0, 1'b1);
        send(23'h000000, 23'h000000, 5'd0,  1'b0, 1'b0);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Saturation of corr_cnt at 2^CNT_W-1.
    for (int i = 0; i < 20; i++) begin
      send(23'h000010, 23'h000010, 5'd5, 1'b1, 1'b0);
    end
    wait_drain();
    check("corr_saturated", 32'(bus.corr_cnt), 32'd15);

    // Reset with both stages full: everything clears at once, nothing stale appears later.
    send(23'h000010, 23'h000010, 5'd5, 1'b1, 1'b0);
    send(23'h008080, 23'h000000, 5'd24, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_corr_cnt", 32'(bus.corr_cnt), 32'd0);
    check("midrst_uncorr_cnt", 32'(bus.uncorr_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
    check("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hamming23_syndrome_pipe.md
Name: hamming23_syndrome_pipe

Overview:
- Two-stage pipelined error-locator stage directly upstream of the 23-bit correction XOR.
- Accepts a received 23-bit Hamming(23,18) codeword, computes its 5-bit syndrome and decodes it into a one-hot 23-bit error mask.
- Presents the delayed received word and the mask together, so the downstream XOR of the two yields the corrected codeword.
- Keeps saturating statistics counters of corrected and uncorrectable words.

Parameters:
- CNT_W, 16, width of each statistics counter (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_word is valid this cycle.
- in_ready  out  1  stage can accept in_word this cycle.
- in_word  in  23  received codeword; bit i is code position i+1.
- out_valid  out  1  out_word, out_mask and flags are valid.
- out_ready  in  1  downstream accepts the output this cycle.
- out_word  out  23  received word, unchanged, aligned with out_mask.
- out_mask  out  23  error mask to XOR with out_word.
- out_syn  out  5  syndrome of out_word.
- out_corr  out  1  single-bit error located; mask is nonzero.
- out_uncorr  out  1  syndrome is 24..31 (no such position); mask is zero.
- corr_cnt  out  CNT_W  count of words delivered with out_corr=1.
- uncorr_cnt  out  CNT_W  count of words delivered with out_uncorr=1.

Behaviour:
- Reset: applying rst_n low asynchronously clears every register. While reset is held:
  - out_valid=0, in_ready=0.
  - out_word, out_mask, out_syn, out_corr, out_uncorr, corr_cnt and uncorr_cnt are all 0.
  - In-flight words are discarded.
- in_ready goes high in the first cycle after rst_n deasserts.
- Syndrome: syn[k] is the XOR of in_word[i] over all i in 0..22 with bit k of (i+1) set, for k=0..4. Parity positions are 1, 2, 4, 8 and 16.
- Stage 1 (S1) registers: valid, the word and the syndrome.
- Stage 2 (S2) registers: valid, the word, the syndrome, the mask and the flags. The S2 registers drive all out_* ports.
- Mask decode in S1->S2 (syn is the S1 syndrome):
  - syn=0: mask=0, corr=0, uncorr=0.
  - syn=1..23: mask bit (syn-1) set, all other bits 0, corr=1, uncorr=0.
  - syn=24..31: mask=0, corr=0, uncorr=1.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - S2 advances when S2 is empty or an output transfer occurs.
  - S1 advances when S1 is empty or S2 advances.
  - in_ready equals the S1-advance condition. It is combinational from out_ready, with no registered skid.
- Latency and throughput:
  - Latency is 2 cycles: a word accepted at edge n appears at out_* after edge n+1, with no stall.
  - Throughput is one word per cycle.
- Stall:
  - While out_valid && !out_ready, all S2 outputs hold stable.
  - S1 holds if occupied, and in_ready=0 when S1 is occupied.
- Bubbles: a stage whose valid bit is 0 may take any data. Data is never qualified without valid.
- Counters:
  - corr_cnt increments on each output transfer with out_corr=1; uncorr_cnt does the same for out_uncorr=1.
  - Both saturate at 2^CNT_W-1, with no wrap.
  - Counting happens only on the transfer, never while a word is stalled.
- Simultaneous events: a full pipeline with out_ready=1 and in_valid=1 shifts all stages and loses no word.
- Reset mid-operation: both valid bits clear immediately, and words in flight are lost and never counted.

Test Plan:
- Reset with in_valid=0, then release:
  - All outputs read 0 during reset.
  - in_ready=1 in the first cycle after release.
- Clean word: in_word=23'h000000 with out_ready=1 -> two cycles later out_valid=1, out_syn=0, out_mask=0, corr=0, uncorr=0, and the counters are unchanged.
- Single error: in_word=23'h000010 (position 5) -> out_syn=5, out_mask=23'h000010, out_corr=1, corr_cnt=1, and out_word^out_mask=0.
- Invalid syndrome: in_word=23'h008080 (positions 8 and 16) -> out_syn=24, out_mask=0, out_uncorr=1, uncorr_cnt=1.
- Backpressure:
  - Stream 4 words back-to-back with out_ready=0 for cycles 2..5.
  - Pipeline fills, then in_ready=0; outputs are stable while stalled.
  - After release, all 4 words exit in order with no loss or duplication, and counters increment once per transfer.
- Saturation and reset:
  - With CNT_W=4, send 20 single-error words -> corr_cnt stops at 15.
  - Assert rst_n low while both stages are full -> out_valid=0 and counters=0 immediately, and no stale word appears after release.
